// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: drives memory address select, write strobe, MDR capture and
// size selects for LW/LH/LB/SW/SH/SB, absorbing memory latency and doing RMW for SH/SB.
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  output logic [1:0] Mux_MEM,
  output logic       MEM_w,
  output logic       MEM_DATA_REG_w,
  output logic [1:0] LS_control,
  output logic [1:0] SS_control,
  output logic       Banco_reg_w,
  output logic       ready,
  output logic       done,
  output logic       exc_misalign
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_CAPTURE, S_WB, S_WRITE, S_EXC
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
  localparam logic [2:0] OP_SW  = 3'b100;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic       w_legal, w_misalign, w_busy;

  logic [1:0] r_mux, w_mux;
  logic [1:0] r_ls, w_ls;
  logic [1:0] r_ss, w_ss;
  logic       r_mem_w, r_mdr_w, r_banco, r_ready, r_done, r_exc;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_legal     = (op[1:0] != 2'b11);
    w_misalign  = ((op[1:0] == 2'b00) && (addr_lo != 2'b00)) ||
                  ((op[1:0] == 2'b01) && addr_lo[0]);
    case (r_state)
      // r_ready gates acceptance so the cycle right after reset also ignores start
      S_IDLE: begin
        if (start && r_ready && w_legal) begin
          if (w_misalign) begin
            w_state_nxt = S_EXC;
          end else begin
            w_state_nxt = S_ADDR;
            w_op_nxt    = op;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      S_ADDR: begin
        if (r_op == OP_SW)          w_state_nxt = S_WRITE;
        else if (MEM_LATENCY == 1)  w_state_nxt = S_CAPTURE;
        else                        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) w_state_nxt = S_CAPTURE;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_CAPTURE: w_state_nxt = r_op[2] ? S_WRITE : S_WB;
      S_WB, S_WRITE, S_EXC: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state
    w_busy = (w_state_nxt != S_IDLE) && (w_state_nxt != S_EXC);
    w_mux  = w_busy ? 2'b10 : 2'b00;
    w_ls   = (w_busy && !w_op_nxt[2]) ? w_op_nxt[1:0] : 2'b00;
    w_ss   = (w_busy &&  w_op_nxt[2]) ? w_op_nxt[1:0] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_mux   <= '0;
      r_ls    <= '0;
      r_ss    <= '0;
      r_mem_w <= 1'b0;
      r_mdr_w <= 1'b0;
      r_banco <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_mux   <= w_mux;
      r_ls    <= w_ls;
      r_ss    <= w_ss;
      r_mem_w <= (w_state_nxt == S_WRITE);
      r_mdr_w <= (w_state_nxt == S_CAPTURE);
      r_banco <= (w_state_nxt == S_WB);
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (w_state_nxt == S_WB) || (w_state_nxt == S_WRITE);
      r_exc   <= (w_state_nxt == S_EXC);
    end
  end

  assign Mux_MEM        = r_mux;
  assign MEM_w          = r_mem_w;
  assign MEM_DATA_REG_w = r_mdr_w;
  assign LS_control     = r_ls;
  assign SS_control     = r_ss;
  assign Banco_reg_w    = r_banco;
  assign ready          = r_ready;
  assign done           = r_done;
  assign exc_misalign   = r_exc;

endmodule
